// File: rtl/uart_crc_transmitter.sv
// UART transmitter: start bit, 8 data bits LSB first, CRC-4 (x^4+x+1) LSB first, stop bit.
// Output line and status are registered; the CRC is computed once when the byte is accepted.
module uart_crc_transmitter #(
    parameter int CLKS_PER_BIT = 1042
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       tx_start,
    input  logic [7:0] tx_data,
    input  logic       crc_corrupt,
    output logic       tx,
    output logic       tx_busy,
    output logic       tx_done
);

    localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    typedef enum logic [2:0] {S_IDLE, S_START, S_DATA, S_CRC, S_STOP} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic [3:0]       crc_q, crc_d;
    logic             tx_q, tx_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;
    logic             bit_last;
    logic [2:0]       bit_nxt;

    // Remainder of {d,4'b0} divided by 10011, long division MSB first.
    function automatic logic [3:0] crc4(input logic [7:0] d);
        logic [11:0] r;
        r = {d, 4'b0000};
        for (int i = 11; i >= 4; i--) begin
            if (r[i]) r[i -: 5] = r[i -: 5] ^ 5'b10011;
        end
        return r[3:0];
    endfunction

    assign bit_last = (cnt_q == CNT_MAX);
    assign bit_nxt  = bit_q + 3'd1;

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        bit_d   = bit_q;
        data_d  = data_q;
        crc_d   = crc_q;
        tx_d    = tx_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        if (state_q != S_IDLE) cnt_d = bit_last ? '0 : cnt_q + 1'b1;
        case (state_q)
            S_IDLE: begin
                tx_d   = 1'b1;
                busy_d = 1'b0;
                cnt_d  = '0;
                if (tx_start) begin
                    data_d  = tx_data;
                    crc_d   = crc4(tx_data) ^ {3'b000, crc_corrupt};
                    state_d = S_START;
                    tx_d    = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            S_START: begin
                if (bit_last) begin
                    state_d = S_DATA;
                    bit_d   = 3'd0;
                    tx_d    = data_q[0];
                end
            end
            S_DATA: begin
                if (bit_last) begin
                    if (bit_q == 3'd7) begin
                        state_d = S_CRC;
                        bit_d   = 3'd0;
                        tx_d    = crc_q[0];
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = data_q[bit_nxt];
                    end
                end
            end
            S_CRC: begin
                if (bit_last) begin
                    if (bit_q == 3'd3) begin
                        state_d = S_STOP;
                        bit_d   = 3'd0;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_nxt;
                        tx_d  = crc_q[bit_nxt[1:0]];
                    end
                end
            end
            S_STOP: begin
                // Done cycle is spent in IDLE, so a new request can be accepted in it.
                if (bit_last) begin
                    state_d = S_IDLE;
                    tx_d    = 1'b1;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
            end
            default: begin
                state_d = S_IDLE;
                tx_d    = 1'b1;
                busy_d  = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            bit_q   <= 3'd0;
            data_q  <= 8'h00;
            crc_q   <= 4'h0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            bit_q   <= bit_d;
            data_q  <= data_d;
            crc_q   <= crc_d;
            tx_q    <= tx_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign tx      = tx_q;
    assign tx_busy = busy_q;
    assign tx_done = done_q;

endmodule

// File: tb/tb_uart_crc_transmitter.sv
// Randomised and directed checks of the CRC UART transmitter against a line-level model
// and a behavioural receiver, at a short bit time and at the full 1042-cycle bit time.
module tb_uart_crc_transmitter;

    localparam int CPB_S = 16;
    localparam int CPB_L = 1042;

    logic       clk;
    logic       rst_s, tx_start_s, cor_s, tx_s, busy_s, done_s;
    logic       rst_l, tx_start_l, cor_l, tx_l, busy_l, done_l;
    logic [7:0] tx_data_s, tx_data_l;

    int n_chk  = 0;
    int n_pass = 0;

    uart_crc_transmitter #(.CLKS_PER_BIT(CPB_S)) dut_s (
        .clk(clk), .rst(rst_s), .tx_start(tx_start_s), .tx_data(tx_data_s),
        .crc_corrupt(cor_s), .tx(tx_s), .tx_busy(busy_s), .tx_done(done_s)
    );

    uart_crc_transmitter #(.CLKS_PER_BIT(CPB_L)) dut_l (
        .clk(clk), .rst(rst_l), .tx_start(tx_start_l), .tx_data(tx_data_l),
        .crc_corrupt(cor_l), .tx(tx_l), .tx_busy(busy_l), .tx_done(done_l)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: simulation time limit reached, required finish earlier");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    // Reference CRC: XOR of (x^(k+4) mod p) over the set data bits k, with p = x^4+x+1.
    function automatic logic [3:0] model_crc(input logic [7:0] d);
        logic [4:0] pw;
        logic [3:0] acc;
        pw  = 5'b00001;
        acc = 4'h0;
        for (int k = 0; k < 12; k++) begin
            if (k >= 4 && d[k-4]) acc = acc ^ pw[3:0];
            pw = pw << 1;
            if (pw[4]) pw = pw ^ 5'b10011;
        end
        return acc;
    endfunction

    function automatic logic line_of(input int sel);
        return sel != 0 ? tx_l : tx_s;
    endfunction
    function automatic logic busy_of(input int sel);
        return sel != 0 ? busy_l : busy_s;
    endfunction
    function automatic logic done_of(input int sel);
        return sel != 0 ? done_l : done_s;
    endfunction

    task automatic send(input int sel, input logic [7:0] d, input logic cor);
        @(negedge clk);
        if (sel != 0) begin tx_start_l = 1'b1; tx_data_l = d; cor_l = cor; end
        else          begin tx_start_s = 1'b1; tx_data_s = d; cor_s = cor; end
        @(negedge clk);
        if (sel != 0) tx_start_l = 1'b0;
        else          tx_start_s = 1'b0;
    endtask

    // Follows one frame from its first low cycle to the done cycle; ends at the done cycle's negedge.
    task automatic rx_frame(input int sel, input logic [7:0] d, input logic cor, input string tag);
        int         c, guard, bad, bsy_bad, dn_bad;
        logic [3:0] cr, rx_crc;
        logic [7:0] rx_d, rx_out;
        logic [13:0] ex, smp;
        logic       ln, err;
        c     = (sel != 0) ? CPB_L : CPB_S;
        cr    = model_crc(d) ^ {3'b000, cor};
        ex    = {1'b1, cr, d, 1'b0};
        smp   = '0;
        guard = 0;
        while (line_of(sel) !== 1'b0 && guard < 64) begin
            @(negedge clk);
            guard++;
        end
        chk({tag, "_start_seen"}, 32'(guard < 64), 32'd1);
        if (guard >= 64) return;
        bad = 0; bsy_bad = 0; dn_bad = 0;
        for (int b = 0; b < 14; b++) begin
            for (int k = 0; k < c; k++) begin
                if (b > 0 || k > 0) @(negedge clk);
                ln = line_of(sel);
                if (ln !== ex[b]) bad++;
                if (busy_of(sel) !== 1'b1) bsy_bad++;
                if (done_of(sel) !== 1'b0) dn_bad++;
                if (k == c / 2) smp[b] = ln;
            end
        end
        @(negedge clk);
        chk({tag, "_bit_errs"}, bad, 0);
        chk({tag, "_busy_gaps"}, bsy_bad, 0);
        chk({tag, "_early_done"}, dn_bad, 0);
        chk({tag, "_done_pulse"}, done_of(sel), 1);
        chk({tag, "_idle_line"}, line_of(sel), 1);
        chk({tag, "_busy_low"}, busy_of(sel), 0);
        rx_d   = smp[8:1];
        rx_crc = smp[12:9];
        err    = (model_crc(rx_d) != rx_crc);
        rx_out = err ? 8'h00 : rx_d;
        chk({tag, "_crc_error"}, err, cor);
        chk({tag, "_data_out"}, rx_out, cor ? 8'h00 : d);
    endtask

    initial begin
        logic [7:0] vals [256];
        logic [7:0] tmp;
        int j, zeros, dones;
        rst_s = 1'b1; rst_l = 1'b1;
        tx_start_s = 1'b0; tx_data_s = 8'h00; cor_s = 1'b0;
        tx_start_l = 1'b0; tx_data_l = 8'h00; cor_l = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_tx_s", tx_s, 1);
        chk("rst_busy_s", busy_s, 0);
        chk("rst_done_s", done_s, 0);
        chk("rst_tx_l", tx_l, 1);
        chk("rst_busy_l", busy_l, 0);
        rst_s = 1'b0; rst_l = 1'b0;
        repeat (2) @(negedge clk);

        fork
            begin : short_bit
                send(0, 8'h01, 1'b0);
                rx_frame(0, 8'h01, 1'b0, "t1");

                @(negedge clk);
                tx_start_s = 1'b1; tx_data_s = 8'h00; cor_s = 1'b0;
                @(negedge clk);
                tx_data_s = 8'h80;
                rx_frame(0, 8'h00, 1'b0, "t2a");
                @(negedge clk);
                chk("t2_gap_one_idle", tx_s, 0);
                tx_start_s = 1'b0;
                rx_frame(0, 8'h80, 1'b0, "t2b");

                send(0, 8'h02, 1'b1);
                rx_frame(0, 8'h02, 1'b1, "t3");

                send(0, 8'hC3, 1'b0);
                fork
                    rx_frame(0, 8'hC3, 1'b0, "t4");
                    begin
                        repeat (3 * CPB_S + 3) @(negedge clk);
                        tx_start_s = 1'b1; tx_data_s = 8'h55;
                        @(negedge clk);
                        tx_start_s = 1'b0;
                    end
                join
                zeros = 0; dones = 0;
                repeat (3 * CPB_S) begin
                    @(negedge clk);
                    if (tx_s !== 1'b1) zeros++;
                    if (done_s !== 1'b0) dones++;
                end
                chk("t4_no_queued_frame", zeros, 0);
                chk("t4_single_done", dones, 0);

                send(0, 8'h01, 1'b0);
                repeat (11 * CPB_S + 5) @(negedge clk);
                chk("t5_pre_rst_line", tx_s, 0);
                #2 rst_s = 1'b1;
                #1;
                chk("t5_async_tx", tx_s, 1);
                chk("t5_async_busy", busy_s, 0);
                dones = 0;
                repeat (3) begin
                    @(negedge clk);
                    if (done_s !== 1'b0) dones++;
                end
                chk("t5_no_done", dones, 0);
                rst_s = 1'b0;
                repeat (2) @(negedge clk);
                chk("t5_idle_after", tx_s, 1);
                tmp = 8'($urandom_range(0, 255));
                send(0, tmp, 1'b0);
                rx_frame(0, tmp, 1'b0, "t5_post");

                for (int i = 0; i < 256; i++) vals[i] = 8'(i);
                for (int i = 255; i > 0; i--) begin
                    j = $urandom_range(0, i);
                    tmp = vals[i]; vals[i] = vals[j]; vals[j] = tmp;
                end
                for (int i = 0; i < 256; i++) begin
                    repeat ($urandom_range(0, 3)) @(negedge clk);
                    send(0, vals[i], 1'b0);
                    rx_frame(0, vals[i], 1'b0, "rnd");
                end
            end
            begin : long_bit
                logic [7:0] b;
                for (int i = 0; i < 3; i++) begin
                    repeat ($urandom_range(1, 8)) @(negedge clk);
                    b = 8'($urandom_range(0, 255));
                    send(1, b, 1'b0);
                    rx_frame(1, b, 1'b0, "rnd1042");
                end
            end
        join

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
